// File: rtl/sorter_pkg.sv
// Shared types and constants for the streaming merge sorter.
// Holds the word/index widths, the controller state enum and small helpers used by
// both the top level and the merge datapath.
// Optional feature macro: SORT_DESCEND_EN (consumed in merge_unit.sv).
package sorter_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned DEPTH     = 32;
  localparam int unsigned LOG_DEPTH = 5;
  // Counts and pointers must represent DEPTH itself, hence one extra bit.
  localparam int unsigned IDX_W     = LOG_DEPTH + 1;
  localparam int unsigned PASS_W    = 3;

  typedef logic [DATA_W-1:0]    word_t;
  typedef logic [IDX_W-1:0]     idx_t;
  typedef logic [LOG_DEPTH-1:0] addr_t;
  typedef logic [PASS_W-1:0]    pass_t;

  typedef enum logic [1:0] {
    StLoad,
    StSort,
    StDrain
  } state_e;

  // ceil(log2(cnt)) for cnt in 1..DEPTH.
  function automatic pass_t num_passes(idx_t cnt);
    pass_t p;
    p = '0;
    for (int unsigned i = 0; i < LOG_DEPTH; i++) begin
      if ((idx_t'(1) << i) < cnt) p = pass_t'(i + 1);
    end
    return p;
  endfunction

  function automatic idx_t min_idx(idx_t a, idx_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/merge_unit.sv
// Combinational step of one bottom-up merge pass.
// Given the current pass index (run width = 1 << pass), the frame length, the left/right
// source read pointers, the destination write pointer and the two source words, it picks
// the next element, and computes the pointers for the following cycle, including the
// hop to the next run pair and the restart for the next pass.
// Ports:
//   active_i    - a merge step happens this cycle (drives wr_en_o)
//   pass_i      - current pass index
//   cnt_i       - frame length (1..DEPTH)
//   lptr_i/rptr_i/wptr_i - left, right and destination pointers
//   src_l_i/src_r_i      - source words at lptr_i / rptr_i
//   wr_en_o/wr_data_o    - destination write strobe and word
//   lptr_o/rptr_o/wptr_o - pointers for the next step
//   pass_done_o          - this step writes the last element of the pass
// Optional feature: SORT_DESCEND_EN selects a descending merge comparator.
module merge_unit
  import sorter_pkg::*;
(
  input  logic  active_i,
  input  pass_t pass_i,
  input  idx_t  cnt_i,
  input  idx_t  lptr_i,
  input  idx_t  rptr_i,
  input  idx_t  wptr_i,
  input  word_t src_l_i,
  input  word_t src_r_i,
  output logic  wr_en_o,
  output word_t wr_data_o,
  output idx_t  lptr_o,
  output idx_t  rptr_o,
  output idx_t  wptr_o,
  output logic  pass_done_o
);

  idx_t run_w;
  idx_t blk_w;
  idx_t base;
  idx_t mid;
  idx_t blk_end;
  idx_t wnext;
  logic l_avail;
  logic r_avail;
  logic l_wins;
  logic take_left;

  always_comb begin
    run_w   = idx_t'(1) << pass_i;
    blk_w   = run_w << 1;
    // Run pairs are aligned to 2*run_w, so the pair base falls out of the write pointer.
    base    = wptr_i & ~(blk_w - idx_t'(1));
    mid     = min_idx(base + run_w, cnt_i);
    blk_end = min_idx(base + blk_w, cnt_i);

    l_avail = (lptr_i < mid);
    r_avail = (rptr_i < blk_end);
`ifdef SORT_DESCEND_EN
    l_wins  = (src_l_i >= src_r_i);
`else
    l_wins  = (src_l_i <= src_r_i);
`endif
    // Ties go left, which keeps the merge stable.
    take_left = l_avail && (!r_avail || l_wins);

    wr_en_o   = active_i;
    wr_data_o = take_left ? src_l_i : src_r_i;

    wnext       = wptr_i + idx_t'(1);
    pass_done_o = (wnext == cnt_i);

    if (pass_done_o) begin
      // Next pass: run width doubles to blk_w.
      lptr_o = '0;
      rptr_o = min_idx(blk_w, cnt_i);
      wptr_o = '0;
    end else if (wnext == blk_end) begin
      lptr_o = wnext;
      rptr_o = min_idx(wnext + run_w, cnt_i);
      wptr_o = wnext;
    end else begin
      lptr_o = lptr_i + idx_t'(take_left);
      rptr_o = rptr_i + idx_t'(!take_left);
      wptr_o = wnext;
    end
  end

endmodule

// File: rtl/top.sv
// 32-entry streaming merge sorter, top level.
// LOAD captures one frame into buffer A, SORT runs ceil(log2(count)) bottom-up merge
// passes ping-ponging between buffers A and B (one element per cycle), DRAIN streams the
// sorted frame out with valid/last framing.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in, valid_in, last_in - input word stream; last_in closes the frame
//   out, valid_out, last_out - registered sorted output stream
//   ready               - high while words are accepted (LOAD only)
// Optional feature: SORT_DESCEND_EN (descending order, see merge_unit.sv).
module top
  import sorter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in,
  input  logic              valid_in,
  input  logic              last_in,
  output logic [DATA_W-1:0] out,
  output logic              valid_out,
  output logic              last_out,
  output logic              ready
);

  state_e state_q, state_d;
  idx_t   cnt_q, cnt_d;
  pass_t  npass_q, npass_d;
  pass_t  pass_q, pass_d;
  idx_t   lptr_q, lptr_d;
  idx_t   rptr_q, rptr_d;
  idx_t   wptr_q, wptr_d;
  word_t  out_q, out_d;
  logic   valid_q, valid_d;
  logic   last_q, last_d;
  logic   ready_q, ready_d;

  word_t  buf_a_q [DEPTH];
  word_t  buf_b_q [DEPTH];
  logic   a_we;
  logic   b_we;
  addr_t  wr_addr;
  word_t  wr_data;

  word_t  src_l;
  word_t  src_r;
  word_t  drain_word;

  logic   mu_active;
  logic   mu_wr_en;
  word_t  mu_data;
  idx_t   mu_lptr;
  idx_t   mu_rptr;
  idx_t   mu_wptr;
  logic   mu_done;

  // Even passes read A and write B; odd passes read B and write A.
  always_comb begin
    src_l = pass_q[0] ? buf_b_q[lptr_q[LOG_DEPTH-1:0]] : buf_a_q[lptr_q[LOG_DEPTH-1:0]];
    src_r = pass_q[0] ? buf_b_q[rptr_q[LOG_DEPTH-1:0]] : buf_a_q[rptr_q[LOG_DEPTH-1:0]];
    // After an odd number of passes the result sits in B.
    drain_word = npass_q[0] ? buf_b_q[wptr_q[LOG_DEPTH-1:0]] : buf_a_q[wptr_q[LOG_DEPTH-1:0]];
  end

  merge_unit u_merge (
    .active_i    (mu_active),
    .pass_i      (pass_q),
    .cnt_i       (cnt_q),
    .lptr_i      (lptr_q),
    .rptr_i      (rptr_q),
    .wptr_i      (wptr_q),
    .src_l_i     (src_l),
    .src_r_i     (src_r),
    .wr_en_o     (mu_wr_en),
    .wr_data_o   (mu_data),
    .lptr_o      (mu_lptr),
    .rptr_o      (mu_rptr),
    .wptr_o      (mu_wptr),
    .pass_done_o (mu_done)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    npass_d   = npass_q;
    pass_d    = pass_q;
    lptr_d    = lptr_q;
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    out_d     = out_q;
    valid_d   = valid_q;
    last_d    = last_q;
    a_we      = 1'b0;
    b_we      = 1'b0;
    wr_addr   = wptr_q[LOG_DEPTH-1:0];
    wr_data   = mu_data;
    mu_active = 1'b0;

    unique case (state_q)
      StLoad: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (valid_in) begin
          a_we    = 1'b1;
          wr_addr = cnt_q[LOG_DEPTH-1:0];
          wr_data = in;
          cnt_d   = cnt_q + 1'b1;
          if (last_in || (cnt_q == idx_t'(DEPTH - 1))) begin
            state_d = StSort;
            npass_d = num_passes(cnt_q + 1'b1);
            pass_d  = '0;
            lptr_d  = '0;
            rptr_d  = idx_t'(1);
            wptr_d  = '0;
          end
        end
      end

      StSort: begin
        if (pass_q == npass_q) begin
          state_d = StDrain;
          wptr_d  = '0;
        end else begin
          mu_active = 1'b1;
          a_we      = mu_wr_en && pass_q[0];
          b_we      = mu_wr_en && !pass_q[0];
          wr_addr   = wptr_q[LOG_DEPTH-1:0];
          wr_data   = mu_data;
          lptr_d    = mu_lptr;
          rptr_d    = mu_rptr;
          wptr_d    = mu_wptr;
          if (mu_done) pass_d = pass_q + 1'b1;
        end
      end

      StDrain: begin
        if (wptr_q < cnt_q) begin
          out_d   = drain_word;
          valid_d = 1'b1;
          last_d  = (wptr_q == cnt_q - 1'b1);
          wptr_d  = wptr_q + 1'b1;
        end else begin
          // One cycle after the last beat: close framing and reopen for input.
          valid_d = 1'b0;
          last_d  = 1'b0;
          cnt_d   = '0;
          state_d = StLoad;
        end
      end

      default: state_d = StLoad;
    endcase

    ready_d = (state_d == StLoad);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLoad;
      cnt_q   <= '0;
      npass_q <= '0;
      pass_q  <= '0;
      lptr_q  <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      npass_q <= npass_d;
      pass_q  <= pass_d;
      lptr_q  <= lptr_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ready_q <= ready_d;
    end
  end

  // Buffer storage carries no reset; contents are always written before being read.
  always_ff @(posedge clk) begin
    if (a_we) buf_a_q[wr_addr] <= wr_data;
    if (b_we) buf_b_q[wr_addr] <= wr_data;
  end

  assign out       = out_q;
  assign valid_out = valid_q;
  assign last_out  = last_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the merge sorter: a queue-based frame model predicts every
// output cycle, directed frames pin the model with literal sorted lists and latencies.
module tb_top;

  localparam int DEPTH_TB = 32;
  typedef logic [7:0] byte_q_t [$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d_in = '0;
  logic       d_vin = 1'b0;
  logic       d_lin = 1'b0;
  logic [7:0] d_out;
  logic       d_valid;
  logic       d_last;
  logic       d_ready;

  int n_cmp = 0;
  int n_fail = 0;

  top u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (d_in),
    .valid_in  (d_vin),
    .last_in   (d_lin),
    .out       (d_out),
    .valid_out (d_valid),
    .last_out  (d_last),
    .ready     (d_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] acc [$];
  logic [7:0] m_sorted [$];
  bit         m_busy = 0;
  int         m_e = 0, m_n = 0, m_p = 0;
  int         ecnt = 0, m_close = 0;
  bit         e_valid = 0, e_last = 0, e_ready = 1;
  logic [7:0] e_out = '0;

  always @(posedge clk or negedge rst_n) begin
    int first;
    if (!rst_n) begin
      m_busy = 0;
      acc.delete();
      m_e = 0;
      e_valid = 0;
      e_last = 0;
      e_ready = 1;
      e_out = '0;
    end else begin
      ecnt++;
      if (!m_busy) begin
        if (d_vin) begin
          acc.push_back(d_in);
          if (d_lin || acc.size() == DEPTH_TB) begin
            m_busy = 1;
            m_n = acc.size();
            m_p = 0;
            while ((1 << m_p) < m_n) m_p++;
            m_sorted = acc;
`ifdef SORT_DESCEND_EN
            m_sorted.rsort();
`else
            m_sorted.sort();
`endif
            acc.delete();
            m_e = 0;
            m_close = ecnt;
          end
        end
      end else begin
        m_e++;
        if (m_e == m_p * m_n + m_n + 2) m_busy = 0;
      end
      first = m_p * m_n + 2;
      e_ready = !m_busy;
      e_valid = m_busy && (m_e >= first) && (m_e < first + m_n);
      e_last = e_valid && (m_e == first + m_n - 1);
      if (e_valid) e_out = m_sorted[m_e - first];
    end
  end

  // ---------------- per-cycle compare + capture ----------------
  logic [7:0] cap_q [$];
  bit         cap_done = 0;
  int         cap_lat = -1;

  always @(negedge clk) begin
    chk("ready", int'(d_ready), int'(e_ready));
    chk("valid_out", int'(d_valid), int'(e_valid));
    chk("last_out", int'(d_last), int'(e_last));
    chk("out", int'(d_out), int'(e_out));
    if (d_valid) begin
      cap_q.push_back(d_out);
      if (cap_q.size() == 1) cap_lat = ecnt - m_close;
    end
    if (d_last) cap_done = 1;
  end

  // ---------------- directed frame helper ----------------
  task automatic run_frame(input string name, input byte_q_t words, input bit with_last,
                           input byte_q_t exp, input int exp_lat);
    byte_q_t e;
    e = exp;
`ifdef SORT_DESCEND_EN
    e.reverse();
`endif
    cap_q.delete();
    cap_done = 0;
    cap_lat = -1;
    foreach (words[i]) begin
      @(negedge clk);
      d_in  = words[i];
      d_vin = 1'b1;
      d_lin = with_last && (i == words.size() - 1);
    end
    @(negedge clk);
    d_vin = 1'b0;
    d_lin = 1'b0;
    for (int t = 0; t < 600 && !cap_done; t++) @(negedge clk);
    chk({name, " frame completed"}, int'(cap_done), 1);
    chk({name, " beat count"}, cap_q.size(), e.size());
    foreach (e[i]) begin
      if (i < cap_q.size()) chk($sformatf("%s beat %0d", name, i), int'(cap_q[i]), int'(e[i]));
    end
    chk({name, " first-valid latency"}, cap_lat, exp_lat);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    byte_q_t w, x;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    w = '{36, 44, 56, 49, 26, 127, 11, 38, 90, 46, 59, 27, 4, 125, 61, 62,
          73, 123, 143, 117, 95, 32, 39, 47, 99, 74, 65, 14, 151, 122, 155, 161};
    x = '{4, 11, 14, 26, 27, 32, 36, 38, 39, 44, 46, 47, 49, 56, 59, 61,
          62, 65, 73, 74, 90, 95, 99, 117, 122, 123, 125, 127, 143, 151, 155, 161};
    run_frame("full", w, 1'b1, x, 162);

    w = '{5, 3, 9};
    x = '{3, 5, 9};
    run_frame("partial", w, 1'b1, x, 8);

    w = '{255, 0, 7, 7, 0, 255};
    x = '{0, 0, 7, 7, 255, 255};
    run_frame("dups", w, 1'b1, x, 20);

    w = '{};
    for (int i = 0; i < 40; i++) w.push_back(8'((i * 53 + 17) % 256));
    x = w[0:31];
    x.sort();
    run_frame("overflow", w, 1'b0, x, 162);

    w = '{42};
    x = '{42};
    run_frame("single", w, 1'b1, x, 2);

    // Reset while sorting a full frame.
    for (int i = 0; i < DEPTH_TB; i++) begin
      @(negedge clk);
      d_in  = 8'($urandom_range(0, 255));
      d_vin = 1'b1;
      d_lin = 1'b0;
    end
    @(negedge clk);
    d_vin = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset-in-sort ready", int'(d_ready), 1);
    chk("reset-in-sort valid_out", int'(d_valid), 0);
    chk("reset-in-sort out", int'(d_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    w = '{200, 1, 100};
    x = '{1, 100, 200};
    run_frame("after-reset", w, 1'b1, x, 8);

    // Random traffic: gaps, stray last_in, words offered while busy.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      d_vin = ($urandom_range(0, 3) != 0);
      d_in  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      d_lin = ($urandom_range(0, 11) == 0);
    end
    @(negedge clk);
    d_vin = 1'b0;
    d_lin = 1'b0;
    repeat (400) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
